// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one bit per clock.
// Optional leading-zero mask output enabled by defining BIN2BCD_BLANK_EN.
module bin_to_bcd_seq #(
    parameter int unsigned BIN_W  = 8,
    parameter int unsigned DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
`ifdef BIN2BCD_BLANK_EN
    output logic [DIGITS-1:0]     lz_mask,
`endif
    output logic [4*DIGITS-1:0]   bcd_out
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned CNT_W = $clog2(BIN_W + 1);

    // True when DIGITS decimal digits can hold the largest BIN_W-bit value.
    function automatic bit digits_ok();
        longint unsigned p;
        longint unsigned max_v;
        p     = 64'd1;
        max_v = (BIN_W >= 64) ? {64{1'b1}} : ((64'd1 << BIN_W) - 64'd1);
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (p > max_v) break;
            p = p * 64'd10;
        end
        return p > max_v;
    endfunction

    generate
        if (!digits_ok()) begin : g_bad_digits
            $error("bin_to_bcd_seq: DIGITS too small for BIN_W");
        end
    endgenerate

    typedef enum logic {IDLE = 1'b0, CONV = 1'b1} state_t;

    state_t             state_q;
    state_t             state_d;
    logic [BIN_W-1:0]   bin_q;
    logic [BIN_W-1:0]   bin_d;
    logic [BCD_W-1:0]   bcd_q;
    logic [BCD_W-1:0]   bcd_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic [BCD_W-1:0]   out_d;
    logic               done_d;
    logic [BCD_W-1:0]   adj;
    logic [BCD_W-1:0]   shift_bcd;
    logic [BIN_W-1:0]   shift_bin;
    logic               last;
`ifdef BIN2BCD_BLANK_EN
    logic [DIGITS-1:0]  lz_d;

    // Digit i (i >= 1) is blank when it and every digit above it are zero.
    function automatic logic [DIGITS-1:0] lz_of(input logic [BCD_W-1:0] v);
        logic [DIGITS-1:0] m;
        logic              zero_above;
        m          = '0;
        zero_above = 1'b1;
        for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
            zero_above = zero_above && (v[4*i +: 4] == 4'd0);
            m[i]       = zero_above;
        end
        return m;
    endfunction
`endif

    // Add-3 correction on every working digit, then the joint left shift.
    always_comb begin
        adj = bcd_q;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    assign shift_bcd = {adj[BCD_W-2:0], bin_q[BIN_W-1]};
    assign shift_bin = bin_q << 1;
    assign last      = (cnt_q == CNT_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = CONV;
            CONV:    if (last)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bin_d  = bin_q;
        bcd_d  = bcd_q;
        cnt_d  = cnt_q;
        done_d = 1'b0;
        out_d  = bcd_out;
`ifdef BIN2BCD_BLANK_EN
        lz_d   = lz_mask;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    bin_d = bin_in;
                    bcd_d = '0;
                    cnt_d = CNT_W'(BIN_W);
                end
            end
            CONV: begin
                bin_d = shift_bin;
                bcd_d = shift_bcd;
                cnt_d = cnt_q - CNT_W'(1);
                if (last) begin
                    done_d = 1'b1;
                    out_d  = shift_bcd;
`ifdef BIN2BCD_BLANK_EN
                    lz_d   = lz_of(shift_bcd);
`endif
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            bcd_out <= '0;
`ifdef BIN2BCD_BLANK_EN
            lz_mask <= '0;
`endif
        end else begin
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            busy    <= (state_d == CONV);
            done    <= done_d;
            bcd_out <= out_d;
`ifdef BIN2BCD_BLANK_EN
            lz_mask <= lz_d;
`endif
        end
    end

endmodule
